mem_router_1mns: RTL and testbench
==================================

Name: mem_router_1mns

Overview:
- Parametrised 1-master / N-slave router for the split-transaction 32-bit memory bus (req/ack command phase, resp/rdata response phase).
- Decodes a slave index from an address bit-field and forwards each command to the selected slave.
- Tracks up to MAX_OUTSTANDING in-flight reads and returns their responses to the master in order.
- Unmapped addresses go to an internal error target. Sits between a core's data/instruction port and tile peripherals/memories.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..15).
- SEL_MSB, 31, MSB of the slave-index field in addr.
- SEL_LSB, 30, LSB of the slave-index field in addr.
- MAX_OUTSTANDING, 4, depth of the read-tag FIFO (power of 2, >=1).
- ERR_RDATA, 32'hDEADBEEF, rdata returned for reads to unmapped slaves.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  1  master request
- m_we_i  in  1  write enable
- m_addr_i  in  32  address
- m_be_i  in  4  byte enables
- m_wdata_i  in  32  write data
- m_ack_o  out  1  command accepted
- m_resp_o  out  1  read response valid
- m_rdata_o  out  32  read data
- s_req_o  out  NUM_SLAVES  per-slave request
- s_we_o  out  NUM_SLAVES  per-slave write enable
- s_addr_o  out  32*NUM_SLAVES  per-slave address (slave k at bits [32k+31:32k])
- s_be_o  out  4*NUM_SLAVES  per-slave byte enables
- s_wdata_o  out  32*NUM_SLAVES  per-slave write data
- s_ack_i  in  NUM_SLAVES  per-slave accept
- s_resp_i  in  NUM_SLAVES  per-slave read response
- s_rdata_i  in  32*NUM_SLAVES  per-slave read data
- err_unexp_resp_o  out  1  sticky: a slave responded with no read pending for it

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: tag FIFO empty and err_unexp_resp_o=0. All outputs are combinational: with no request and no pending read, every s_* output is 0 and m_ack_o=m_resp_o=0, m_rdata_o=0.
- Decode: sel = m_addr_i[SEL_MSB:SEL_LSB]. If sel >= NUM_SLAVES, the target is ERR (index NUM_SLAVES).
- Tag FIFO: holds target indices, width IW=$clog2(NUM_SLAVES+1). cnt ranges 0..MAX_OUTSTANDING. pend_tgt = index of the most recently pushed entry.
- Issue gate: go = m_req_i && (cnt==0 || sel_tgt==pend_tgt) && (m_we_i || cnt<MAX_OUTSTANDING).
  - A target switch waits until all reads drain, which guarantees in-order responses.
- Forwarding (go=1, mapped target): s_req_o[sel]=1 and s_we/addr/be/wdata[sel] = master values; m_ack_o = s_ack_i[sel] (combinational, zero latency). All other slaves see zeros.
- Forwarding (go=1, ERR target): m_ack_o=1 in the same cycle. Writes are dropped.
- go=0: all s_req_o=0, m_ack_o=0; the master holds its request.
- Push: on m_req_i && m_ack_o && !m_we_i, the target index is pushed at the clock edge.
- Response mux: when cnt>0, head = FIFO head.
  - head<NUM_SLAVES: m_resp_o=s_resp_i[head], m_rdata_o=s_rdata_i[head].
  - head==ERR: m_resp_o=1, m_rdata_o=ERR_RDATA. This is the earliest cycle after the ack, so error latency is 1 cycle.
- Pop on m_resp_o. Push and pop in the same cycle leave cnt unchanged. The full-plus-pop case still blocks that cycle's read (gate uses the registered cnt).
- Unexpected response: s_resp_i[k]=1 with cnt==0 or k!=head is ignored and sets err_unexp_resp_o, which stays set until reset.
- Zero-latency responses (resp in the same cycle as ack) are not supported. Slaves respond at least 1 cycle after ack.
- Reset mid-operation: FIFO cleared. Responses arriving afterwards are unexpected and set the flag. In-flight writes are not tracked.

Decomposition:
- Package sigma_tile_pkg: MEM_AW=32, MEM_DW=32, MEM_BEW=4, and a function computing IW from NUM_SLAVES.
- Sub-module mem_router_tag_fifo: synchronous FIFO with push/pop/full/empty/count, DEPTH=MAX_OUTSTANDING, WIDTH=IW, and a last-pushed output. It is instantiated once. The router top holds decode, gating and muxing.

Test Plan:
- Single read: NUM_SLAVES=3. Read 0x4000_0010; slave1 acks at once and responds 2 cycles later with 0x1234_5678 -> m_ack_o in the request cycle, m_resp_o=1 with m_rdata_o=0x1234_5678, FIFO empty afterwards.
- Pipelined reads to slave0 with MAX_OUTSTANDING=4: five back-to-back reads, slave always acks, responses delayed 6 cycles -> 4 acks, the 5th stalls (s_req_o=0) until the first response; responses return in order.
- Target switch: read to slave0 pending, then a read to slave2 (0x8000_0000) -> s_req_o[2] stays 0 until slave0 responds, then it issues in the next cycle.
- Unmapped: read 0xC000_0000 with NUM_SLAVES=3 -> m_ack_o same cycle, m_resp_o=1 next cycle with 0xDEADBEEF. A write to the same address is acked with no s_req_o activity.
- Error flag: s_resp_i[1] pulsed with FIFO empty -> err_unexp_resp_o=1 and held. rst_i for 1 cycle -> flag 0 and FIFO empty.
- Simultaneous push/pop: FIFO full (4), slave responds while the master requests a read to the same target -> pop occurs, ack withheld that cycle, accepted the next cycle; cnt ends at 4.

Source files
------------

// File: rtl/sigma_tile_pkg.sv
// Shared widths for the tile memory bus and the router's tag-width helper.
package sigma_tile_pkg;

  localparam int MEM_AW  = 32;
  localparam int MEM_DW  = 32;
  localparam int MEM_BEW = 4;

  // Tag width must also encode the error target, which sits one past the last slave.
  function automatic int tag_width(input int num_slaves);
    return $clog2(num_slaves + 1);
  endfunction

endpackage

// File: rtl/mem_router_tag_fifo.sv
// In-order FIFO of read-target tags, with a copy of the most recently pushed tag.
module mem_router_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] last,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full    = (32'(count_reg) == DEPTH);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign last    = last_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read combinationally so an error-target response can fire the cycle after its ack.
  assign head = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        last_reg   <= push_data;
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/mem_router_1mns.sv
// One-master / N-slave split-transaction bus router with in-order read return
// and an internal error target for unmapped addresses.
module mem_router_1mns
  import sigma_tile_pkg::*;
#(
  parameter int                NUM_SLAVES      = 4,
  parameter int                SEL_MSB         = 31,
  parameter int                SEL_LSB         = 30,
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [MEM_DW-1:0] ERR_RDATA       = 32'hDEADBEEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          m_req_i,
  input  logic                          m_we_i,
  input  logic [MEM_AW-1:0]             m_addr_i,
  input  logic [MEM_BEW-1:0]            m_be_i,
  input  logic [MEM_DW-1:0]             m_wdata_i,
  output logic                          m_ack_o,
  output logic                          m_resp_o,
  output logic [MEM_DW-1:0]             m_rdata_o,
  output logic [NUM_SLAVES-1:0]         s_req_o,
  output logic [NUM_SLAVES-1:0]         s_we_o,
  output logic [MEM_AW*NUM_SLAVES-1:0]  s_addr_o,
  output logic [MEM_BEW*NUM_SLAVES-1:0] s_be_o,
  output logic [MEM_DW*NUM_SLAVES-1:0]  s_wdata_o,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES-1:0]         s_resp_i,
  input  logic [MEM_DW*NUM_SLAVES-1:0]  s_rdata_i,
  output logic                          err_unexp_resp_o
);

  localparam int            IW      = tag_width(NUM_SLAVES);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] ERR_TGT = IW'(NUM_SLAVES);

  logic [IW-1:0]         sel_tgt;
  logic [IW-1:0]         head_tgt;
  logic [IW-1:0]         pend_tgt;
  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  go;
  logic                  tgt_err;
  logic                  push;
  logic [NUM_SLAVES-1:0] fwd;
  logic [NUM_SLAVES-1:0] ack_vec;
  logic [NUM_SLAVES-1:0] unexp_vec;
  logic                  err_unexp_reg;

  always_comb begin
    sel_tgt = ERR_TGT;
    if (32'(m_addr_i[SEL_MSB:SEL_LSB]) < NUM_SLAVES) begin
      sel_tgt = IW'(m_addr_i[SEL_MSB:SEL_LSB]);
    end
  end

  assign tgt_err = (sel_tgt == ERR_TGT);

  // Switching target only after all reads drain keeps responses in issue order.
  assign go = m_req_i
           && (fifo_cnt == '0 || sel_tgt == pend_tgt)
           && (m_we_i || !fifo_full);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    localparam logic [IW-1:0] IDX = IW'(gi);
    assign fwd[gi]                               = go && (sel_tgt == IDX);
    assign s_req_o[gi]                           = fwd[gi];
    assign s_we_o[gi]                            = fwd[gi] & m_we_i;
    assign s_addr_o[gi*MEM_AW +: MEM_AW]         = fwd[gi] ? m_addr_i  : '0;
    assign s_be_o[gi*MEM_BEW +: MEM_BEW]         = fwd[gi] ? m_be_i    : '0;
    assign s_wdata_o[gi*MEM_DW +: MEM_DW]        = fwd[gi] ? m_wdata_i : '0;
    assign ack_vec[gi]                           = fwd[gi] & s_ack_i[gi];
    assign unexp_vec[gi] = s_resp_i[gi] && (fifo_empty || head_tgt != IDX);
  end

  assign m_ack_o = go && (tgt_err || (|ack_vec));
  assign push    = m_req_i && m_ack_o && !m_we_i;

  always_comb begin
    m_resp_o  = 1'b0;
    m_rdata_o = '0;
    if (!fifo_empty) begin
      if (head_tgt == ERR_TGT) begin
        m_resp_o  = 1'b1;
        m_rdata_o = ERR_RDATA;
      end else begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
          if (head_tgt == IW'(k)) begin
            m_resp_o  = s_resp_i[k];
            m_rdata_o = s_rdata_i[k*MEM_DW +: MEM_DW];
          end
        end
      end
    end
  end

  mem_router_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (sel_tgt),
    .pop       (m_resp_o),
    .head      (head_tgt),
    .last      (pend_tgt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_unexp_reg <= 1'b0;
    end else if (|unexp_vec) begin
      err_unexp_reg <= 1'b1;
    end
  end

  assign err_unexp_resp_o = err_unexp_reg;

endmodule

// File: tb/tb_mem_router_1mns.sv
// Directed bench for mem_router_1mns: slave models with programmable latency
// and a read-data scoreboard fed on master acks.
module tb_mem_router_1mns;

  localparam int          NS   = 3;
  localparam int          MO   = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  typedef struct {
    int          due;
    logic [31:0] data;
  } slv_item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             m_req, m_we, m_ack, m_resp;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic [3:0]       m_be;
  logic [NS-1:0]    s_req, s_we, s_ack, s_resp;
  logic [32*NS-1:0] s_addr, s_wdata, s_rdata;
  logic [4*NS-1:0]  s_be;
  logic             err_unexp;
  logic [NS-1:0]    slv_resp = '0;
  logic [NS-1:0]    inj_resp = '0;
  logic [NS-1:0]    hold = '0;

  assign s_resp = slv_resp | inj_resp;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat [NS];
  logic [31:0] exp_next [NS];
  logic [31:0] slv_next [NS];
  logic [31:0] sb_q [$];
  slv_item_t   slv_q [NS][$];

  mem_router_1mns #(
    .NUM_SLAVES      (NS),
    .SEL_MSB         (31),
    .SEL_LSB         (30),
    .MAX_OUTSTANDING (MO),
    .ERR_RDATA       (ERRD)
  ) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .m_req_i          (m_req),
    .m_we_i           (m_we),
    .m_addr_i         (m_addr),
    .m_be_i           (m_be),
    .m_wdata_i        (m_wdata),
    .m_ack_o          (m_ack),
    .m_resp_o         (m_resp),
    .m_rdata_o        (m_rdata),
    .s_req_o          (s_req),
    .s_we_o           (s_we),
    .s_addr_o         (s_addr),
    .s_be_o           (s_be),
    .s_wdata_o        (s_wdata),
    .s_ack_i          (s_ack),
    .s_resp_i         (s_resp),
    .s_rdata_i        (s_rdata),
    .err_unexp_resp_o (err_unexp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave models: respond `lat` cycles after accepting a read, in accept order.
  initial begin
    s_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      for (int k = 0; k < NS; k++) begin
        slv_resp[k]        = 1'b0;
        s_rdata[k*32 +: 32] = '0;
        if (slv_q[k].size() > 0 && !hold[k] && slv_q[k][0].due <= cyc) begin
          slv_resp[k]         = 1'b1;
          s_rdata[k*32 +: 32] = slv_q[k][0].data;
        end
      end
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        if (slv_resp[k]) void'(slv_q[k].pop_front());
        if (s_req[k] && s_ack[k] && !s_we[k]) begin
          slv_q[k].push_back('{due: cyc + lat[k], data: slv_next[k]});
          slv_next[k] = slv_next[k] + 1;
        end
      end
    end
  end

  // Scoreboard: expected read data queued on ack, compared on response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_resp) begin
          check("sb_resp_has_pending", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) check("sb_rdata", m_rdata, sb_q.pop_front());
        end
        if (m_req && m_ack && !m_we) begin
          if (m_addr[31:30] >= 2'(NS)) begin
            sb_q.push_back(ERRD);
          end else begin
            sb_q.push_back(exp_next[m_addr[31:30]]);
            exp_next[m_addr[31:30]] = exp_next[m_addr[31:30]] + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input int maxc);
    int n = 0;
    int busy = 1;
    while (busy != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
      busy = sb_q.size();
      for (int k = 0; k < NS; k++) busy += slv_q[k].size();
    end
    check("drain_in_budget", 32'(n < maxc), 32'd1);
    @(posedge clk);
    #1;
    check("drain_fifo_cnt", 32'(u_dut.fifo_cnt), 32'd0);
  endtask

  initial begin
    int stall;
    int blk;
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = '1;
    for (int k = 0; k < NS; k++) begin
      lat[k]      = 2;
      exp_next[k] = 32'h1000_0000 * (k + 1);
      slv_next[k] = 32'h1000_0000 * (k + 1);
    end
    exp_next[1] = 32'h1234_5678;
    slv_next[1] = 32'h1234_5678;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_resp", 32'(m_resp), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_s_all_zero", 32'(|{s_req, s_we, s_addr, s_be, s_wdata}), 32'd0);
    check("rst_err_flag", 32'(err_unexp), 32'd0);
    check("rst_fifo_cnt", 32'(u_dut.fifo_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read to slave 1, response 2 cycles after ack
    @(posedge clk); #1 m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0010; m_be = 4'hF;
    @(negedge clk);
    check("t1_ack", 32'(m_ack), 32'd1);
    check("t1_s_req", 32'(s_req), 32'b010);
    check("t1_s_addr", s_addr[32 +: 32], 32'h4000_0010);
    @(posedge clk); #1 m_req = 1'b0;
    @(negedge clk);
    check("t1_resp_early", 32'(m_resp), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_resp", 32'(m_resp), 32'd1);
    check("t1_rdata", m_rdata, 32'h1234_5678);
    @(posedge clk); @(negedge clk);
    check("t1_fifo_empty", 32'(u_dut.fifo_cnt), 32'd0);

    // Mapped write to slave 2
    @(posedge clk); #1 m_req = 1'b1; m_we = 1'b1; m_addr = 32'h8000_0020; m_be = 4'h3; m_wdata = 32'hCAFE_0001;
    @(negedge clk);
    check("wr_ack", 32'(m_ack), 32'd1);
    check("wr_s_we", 32'(s_we), 32'b100);
    check("wr_s_wdata", s_wdata[64 +: 32], 32'hCAFE_0001);
    check("wr_s_be", 32'(s_be[8 +: 4]), 32'h3);
    @(posedge clk); #1 m_req = 1'b0; m_we = 1'b0;

    // Five back-to-back reads to slave 0, 6-cycle latency: 5th stalls 3 cycles
    lat[0] = 6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100 + 32'(4 * i);
      stall = 0;
      @(negedge clk);
      while (!m_ack && stall < 20) begin
        check("t2_stall_s_req", 32'(s_req), 32'd0);
        stall++;
        @(posedge clk); @(negedge clk);
      end
      check($sformatf("t2_stall_cycles_%0d", i), 32'(stall), (i < 4) ? 32'd0 : 32'd3);
    end
    @(posedge clk); #1 m_req = 1'b0;
    wait_drain(40);

    // Target switch: read to slave 2 waits for slave 0 to drain
    lat[0] = 3; lat[2] = 1;
    @(posedge clk); #1 m_req = 1'b1; m_addr = 32'h0000_0200;
    @(negedge clk);
    check("t3_first_ack", 32'(m_ack), 32'd1);
    @(posedge clk); #1 m_addr = 32'h8000_0000;
    blk = 0;
    @(negedge clk);
    while (!m_ack && blk < 20) begin
      check("t3_s_req2_low", 32'(s_req[2]), 32'd0);
      blk++;
      @(posedge clk); @(negedge clk);
    end
    check("t3_blocked_cycles", 32'(blk), 32'd3);
    check("t3_s_req_on_issue", 32'(s_req), 32'b100);
    @(posedge clk); #1 m_req = 1'b0;
    wait_drain(20);

    // Unmapped read and write
    @(posedge clk); #1 m_req = 1'b1; m_we = 1'b0; m_addr = 32'hC000_0000;
    @(negedge clk);
    check("t4_rd_ack", 32'(m_ack), 32'd1);
    check("t4_rd_no_s_req", 32'(s_req), 32'd0);
    @(posedge clk); #1 m_req = 1'b0;
    @(negedge clk);
    check("t4_rd_resp", 32'(m_resp), 32'd1);
    check("t4_rd_rdata", m_rdata, ERRD);
    @(posedge clk); #1 m_req = 1'b1; m_we = 1'b1; m_addr = 32'hC000_0004; m_wdata = 32'h55;
    @(negedge clk);
    check("t4_wr_ack", 32'(m_ack), 32'd1);
    check("t4_wr_no_slave", 32'(s_req | s_we), 32'd0);
    @(posedge clk); #1 m_req = 1'b0; m_we = 1'b0;
    @(negedge clk);
    check("t4_wr_no_resp", 32'(m_resp), 32'd0);

    // Full FIFO plus simultaneous pop: ack withheld for one cycle
    hold[0] = 1'b1; lat[0] = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 m_req = 1'b1; m_addr = 32'h0000_0300 + 32'(4 * i);
      @(negedge clk);
      check("t6_fill_ack", 32'(m_ack), 32'd1);
    end
    @(posedge clk); #1 m_addr = 32'h0000_0310;
    @(negedge clk);
    check("t6_full_no_ack", 32'(m_ack), 32'd0);
    check("t6_full_cnt", 32'(u_dut.fifo_cnt), 32'd4);
    @(posedge clk); #1 hold[0] = 1'b0;
    @(negedge clk);
    check("t6_pop_resp", 32'(m_resp), 32'd1);
    check("t6_ack_withheld", 32'(m_ack), 32'd0);
    @(posedge clk); #1 hold[0] = 1'b1;
    @(negedge clk);
    check("t6_ack_next", 32'(m_ack), 32'd1);
    check("t6_no_resp", 32'(m_resp), 32'd0);
    @(posedge clk); #1 m_req = 1'b0;
    @(negedge clk);
    check("t6_cnt_end", 32'(u_dut.fifo_cnt), 32'd4);
    @(posedge clk); #1 hold[0] = 1'b0;
    wait_drain(30);

    // Unexpected response sets a sticky flag cleared only by reset
    @(posedge clk); #1 inj_resp[1] = 1'b1;
    @(negedge clk);
    check("t5_resp_ignored", 32'(m_resp), 32'd0);
    check("t5_flag_before_edge", 32'(err_unexp), 32'd0);
    @(posedge clk); #1 inj_resp = '0;
    @(negedge clk);
    check("t5_flag_set", 32'(err_unexp), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_flag_held", 32'(err_unexp), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_flag_cleared", 32'(err_unexp), 32'd0);
    check("t5_fifo_empty", 32'(u_dut.fifo_cnt), 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("end_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
